alarm_manager: RTL and testbench
================================

Name: alarm_manager

Overview:
Downstream consumer of the burglar, fire and rain alarm flags. It latches each alarm event, arbitrates by priority and drives a patterned siren and buzzer. It also supports user acknowledge and silences non-fire alarms after a timeout. It sits between the sensor-level alarm modules and the home's annunciator outputs.

Parameters:
TICK_DIV, 50000, clk cycles per pattern tick (>=2)
SIREN_TIMEOUT, 600, ticks in ALERT before a non-fire alarm is muted (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
burglar_in  input  1  level alarm from burglar_alarm, synchronous to clk
fire_in  input  1  level alarm from fire, synchronous to clk
rain_in  input  1  level alarm from rain, synchronous to clk
ack  input  1  user acknowledge, synchronous level; edge-detected internally
siren  output  1  patterned siren drive
buzzer  output  1  low-priority beeper drive
active_code  output  2  source being annunciated: 00 none, 01 rain, 10 burglar, 11 fire
alarm_active  output  1  1 when any alarm is pending

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - Pending flags, edge registers, tick counter, phase counter and timeout counter are cleared.
  - State is IDLE.
- Edge detection:
  - Each input and ack is registered once (x_q). A rise is x & ~x_q.
  - A source's pending flag sets on the clock edge where its rise is true. active_code and alarm_active reflect it 1 cycle after the input first samples high.
  - Inputs already high when reset deasserts are not treated as events until they fall and rise again, because x_q resets to 0 then loads at the first edge.
- Priority: fire > burglar > rain. active_code is the highest pending source.
- States:
  - IDLE: no pending flags; siren=0, buzzer=0.
  - ALERT: at least one flag pending; outputs patterned.
  - MUTED: pending but silenced; siren=0, buzzer=0; active_code and alarm_active stay valid.
- Transitions:
  - IDLE -> ALERT on any rise.
  - ALERT -> MUTED when the timeout counter reaches SIREN_TIMEOUT and active_code != 11.
  - MUTED -> ALERT on any new rise; the timeout restarts.
  - ALERT/MUTED on ack rise: clear the flag of the current active_code source. If flags remain, go to (or stay in) ALERT with the timeout restarted; otherwise go to IDLE.
  - Ack in IDLE is ignored.
- Simultaneous events:
  - A rise and an ack of the same source in one cycle: the set wins and the flag stays.
  - A rise of a higher source while lower ones are pending: active_code switches immediately, and the phase and timeout counters restart.
- Tick: 1-cycle pulse every TICK_DIV clk cycles, free-running from reset.
- Phase: 2-bit counter, increments on tick in ALERT, wraps 3->0. It is zeroed on entering ALERT and on an active_code change.
- Patterns in ALERT:
  - fire: siren=1 continuously.
  - burglar: siren = ~phase[0].
  - rain: siren=0, buzzer=1 only when phase==0.
- Fire never times out. Its timeout counter is held at 0 while active_code==11.
- Timeout counter:
  - Width is $clog2(SIREN_TIMEOUT+1).
  - Increments on tick in ALERT and saturates at SIREN_TIMEOUT.
  - Held at 0 outside ALERT.
- Reset mid-alarm: everything returns to reset values in the same instant; no alarm memory survives.

Optional Feature:
- Macro: ALARM_LOG_EN.
- With it defined:
  - Adds output event_count [23:0]: three 8-bit saturating counters (fire [23:16], burglar [15:8], rain [7:0]).
  - Each counter increments on every rise of its source, including rises while already pending, and saturates at 255.
  - Cleared only by reset.
- Without it: the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alarm_pkg:
  - state enum (IDLE, ALERT, MUTED).
  - active_code constants CODE_NONE/RAIN/BURGLAR/FIRE.
  - Priority order.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick): modulo counter emitting a 1-cycle tick.

Test Plan (TICK_DIV=4, SIREN_TIMEOUT=8):
- Reset asserted mid-ALERT with fire pending -> outputs 0 asynchronously, state IDLE. After release, fire_in held high produces no alarm until it toggles.
- Single rain_in rise -> after 1 cycle active_code=01, alarm_active=1, buzzer high for 4 cycles of every 16, siren=0. After 8 ticks (32 cycles) -> MUTED, buzzer=0, active_code still 01.
- burglar_in rise -> siren toggles every 4 cycles (on 4, off 4). fire_in rise while burglar pending -> active_code=11 next cycle, siren solid, no mute after 100 ticks. First ack -> active_code=10, siren pattern restarts at phase 0. Second ack -> IDLE, all outputs 0.
- burglar rise and ack in the same cycle while burglar is active -> burglar flag remains, active_code=10.
- Rain muted, then new burglar rise -> ALERT, active_code=10, timeout restarts; ack -> back to ALERT with rain (01), buzzer pattern resumes.
- ALARM_LOG_EN: 300 fire_in pulses -> event_count[23:16]=255, other fields 0. Without the macro, elaboration has no event_count port.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types for the alarm annunciator: FSM states, active_code values and
// the fire > burglar > rain priority helpers.
package alarm_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ALERT, ST_MUTED} state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_RAIN    = 2'b01;
  localparam logic [1:0] CODE_BURGLAR = 2'b10;
  localparam logic [1:0] CODE_FIRE    = 2'b11;

  // Source vector bit positions; the code value is the bit index plus one.
  localparam int SRC_RAIN    = 0;
  localparam int SRC_BURGLAR = 1;
  localparam int SRC_FIRE    = 2;
  localparam int NUM_SRC     = 3;

  function automatic logic [1:0] top_code(input logic [NUM_SRC-1:0] p);
    if (p[SRC_FIRE])         return CODE_FIRE;
    else if (p[SRC_BURGLAR]) return CODE_BURGLAR;
    else if (p[SRC_RAIN])    return CODE_RAIN;
    else                     return CODE_NONE;
  endfunction

  function automatic logic [NUM_SRC-1:0] code_mask(input logic [1:0] c);
    case (c)
      CODE_RAIN:    return 3'b001;
      CODE_BURGLAR: return 3'b010;
      CODE_FIRE:    return 3'b100;
      default:      return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alarm_manager_tick_gen.sv
// Free-running modulo counter producing a 1-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/alarm_manager.sv
// Alarm annunciator: latches rain/burglar/fire events, arbitrates by priority
// and drives patterned siren/buzzer. Define ALARM_LOG_EN for event_count.
module alarm_manager
  import alarm_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int SIREN_TIMEOUT = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       burglar_in,
  input  logic       fire_in,
  input  logic       rain_in,
  input  logic       ack,
  output logic       siren,
  output logic       buzzer,
  output logic [1:0] active_code,
  output logic       alarm_active
`ifdef ALARM_LOG_EN
  ,
  output logic [23:0] event_count
`endif
);
  localparam int TW = $clog2(SIREN_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(SIREN_TIMEOUT);

  logic [NUM_SRC-1:0] src, src_q, rise, pend, pend_n;
  logic               ack_q, ack_rise, ack_eff, armed, tick, restart;
  logic [1:0]         code, code_n, phase, phase_n;
  logic [TW-1:0]      tmo, tmo_n;
  state_t             state, state_n;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign src = {fire_in, burglar_in, rain_in};

  // The first edge after reset only loads the history registers, so a level
  // already high at release is not mistaken for a new event.
  assign rise     = src & ~src_q & {NUM_SRC{armed}};
  assign ack_rise = ack & ~ack_q & armed;
  assign code     = top_code(pend);

  always_comb begin
    ack_eff = ack_rise && (state != ST_IDLE);
    pend_n  = pend;
    if (ack_eff) pend_n = pend_n & ~code_mask(code);
    pend_n  = pend_n | rise;
    code_n  = top_code(pend_n);

    state_n = state;
    if (pend_n == '0)
      state_n = ST_IDLE;
    else if ((|rise) || ack_eff)
      state_n = ST_ALERT;
    else if (state == ST_ALERT && tmo == TMO_MAX && code != CODE_FIRE)
      state_n = ST_MUTED;

    restart = (state_n == ST_ALERT) &&
              ((state != ST_ALERT) || (code_n != code) || ack_eff);

    phase_n = phase;
    tmo_n   = tmo;
    if (state_n != ST_ALERT || restart) begin
      phase_n = '0;
      tmo_n   = '0;
    end else begin
      if (tick) phase_n = phase + 2'd1;
      if (code_n == CODE_FIRE)          tmo_n = '0;
      else if (tick && tmo != TMO_MAX)  tmo_n = tmo + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
      src_q <= '0;
      ack_q <= 1'b0;
      pend  <= '0;
      state <= ST_IDLE;
      phase <= '0;
      tmo   <= '0;
    end else begin
      armed <= 1'b1;
      src_q <= src;
      ack_q <= ack;
      pend  <= pend_n;
      state <= state_n;
      phase <= phase_n;
      tmo   <= tmo_n;
    end
  end

  // Outputs decode straight from registers so reset clears them immediately.
  assign siren        = (state == ST_ALERT) &&
                        ((code == CODE_FIRE) || (code == CODE_BURGLAR && !phase[0]));
  assign buzzer       = (state == ST_ALERT) && (code == CODE_RAIN) && (phase == 2'd0);
  assign active_code  = code;
  assign alarm_active = |pend;

`ifdef ALARM_LOG_EN
  logic [NUM_SRC-1:0][7:0] ev_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_log
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                          ev_cnt[i] <= '0;
      else if (rise[i] && ev_cnt[i] != 8'hFF) ev_cnt[i] <= ev_cnt[i] + 8'd1;
    end
  end

  assign event_count = ev_cnt;
`endif

endmodule

// File: tb/tb_alarm_manager.sv
// Randomized + directed scoreboard bench for alarm_manager (TICK_DIV=4,
// SIREN_TIMEOUT=8) against a rule-level reference model.
module tb_alarm_manager;
  localparam int TD = 4;
  localparam int ST = 8;
  localparam int M_IDLE = 0, M_ALERT = 1, M_MUTED = 2;

  logic       clk = 1'b0, reset = 1'b1;
  logic       burglar_in = 1'b0, fire_in = 1'b0, rain_in = 1'b0, ack = 1'b0;
  logic       siren, buzzer, alarm_active;
  logic [1:0] active_code;
  logic [23:0] event_count;

  alarm_manager #(.TICK_DIV(TD), .SIREN_TIMEOUT(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .burglar_in  (burglar_in),
    .fire_in     (fire_in),
    .rain_in     (rain_in),
    .ack         (ack),
    .siren       (siren),
    .buzzer      (buzzer),
    .active_code (active_code),
    .alarm_active(alarm_active)
`ifdef ALARM_LOG_EN
    ,
    .event_count (event_count)
`endif
  );

`ifndef ALARM_LOG_EN
  assign event_count = '0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  o;   // {siren, buzzer, active_code, alarm_active}
    logic [23:0] ev;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, passed = 0;

  // Reference model: sources indexed 0 rain, 1 burglar, 2 fire.
  int m_pend[3], m_prev[3], m_ev[3];
  int m_prev_ack, m_armed, m_mode, m_ph, m_to, m_tc;

  function automatic int m_code();
    if (m_pend[2] != 0) return 3;
    if (m_pend[1] != 0) return 2;
    if (m_pend[0] != 0) return 1;
    return 0;
  endfunction

  task automatic model_clock();
    int cur[3];
    int r[3];
    int tk, a, acked, any, oc, om, nc;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin m_pend[i] = 0; m_prev[i] = 0; m_ev[i] = 0; end
      m_prev_ack = 0; m_armed = 0; m_mode = M_IDLE; m_ph = 0; m_to = 0; m_tc = 0;
      return;
    end
    tk   = (m_tc == TD - 1);
    m_tc = (m_tc + 1) % TD;
    cur[0] = rain_in; cur[1] = burglar_in; cur[2] = fire_in;
    for (int i = 0; i < 3; i++) begin
      r[i] = m_armed && cur[i] && !m_prev[i];
      m_prev[i] = cur[i];
      if (r[i] && m_ev[i] < 255) m_ev[i]++;
    end
    a = m_armed && ack && !m_prev_ack;
    m_prev_ack = ack;
    m_armed = 1;
    oc = m_code();
    om = m_mode;
    acked = a && (m_mode != M_IDLE);
    if (acked) m_pend[oc - 1] = 0;
    any = 0;
    for (int i = 0; i < 3; i++) if (r[i]) begin m_pend[i] = 1; any = 1; end
    nc = m_code();
    if (nc == 0)                                    m_mode = M_IDLE;
    else if (any || acked)                          m_mode = M_ALERT;
    else if (m_mode == M_ALERT && m_to == ST && nc != 3) m_mode = M_MUTED;
    if (m_mode != M_ALERT || om != M_ALERT || nc != oc || acked) begin
      m_ph = 0; m_to = 0;
    end else begin
      if (tk) m_ph = (m_ph + 1) % 4;
      if (nc == 3)                m_to = 0;
      else if (tk && m_to < ST)   m_to++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int c = m_code();
    logic s, b;
    s = (m_mode == M_ALERT) && (c == 3 || (c == 2 && m_ph % 2 == 0));
    b = (m_mode == M_ALERT) && (c == 1) && (m_ph == 0);
    e.o  = {s, b, 2'(c), logic'(c != 0)};
    e.ev = {8'(m_ev[2]), 8'(m_ev[1]), 8'(m_ev[0])};
    return e;
  endfunction

  // Inputs are applied just after a rising edge; the model then advances on
  // the next edge and queues what the DUT must show afterwards.
  task automatic drive(input logic f, input logic b, input logic r, input logic a);
    fire_in = f; burglar_in = b; rain_in = r; ack = a;
    @(posedge clk);
    #1;
    model_clock();
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input logic f, input logic b, input logic r, input logic a, input int n);
    for (int i = 0; i < n; i++) drive(f, b, r, a);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({siren, buzzer, active_code, alarm_active} == 5'b0 && event_count == 24'b0) passed++;
    else $display("FAIL async_reset: got outputs=%b ev=%h, want all zero",
                  {siren, buzzer, active_code, alarm_active}, event_count);
    for (int i = 0; i < n; i++) drive(fire_in, burglar_in, rain_in, ack);
    reset = 1'b0;
  endtask

  // Monitor: one comparison per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({siren, buzzer, active_code, alarm_active} == e.o
`ifdef ALARM_LOG_EN
            && event_count == e.ev
`endif
           ) passed++;
        else $display("FAIL outputs @%0t: got s/b/code/act=%b ev=%h, want %b ev=%h",
                      $time, {siren, buzzer, active_code, alarm_active}, event_count,
                      e.o, e.ev);
      end
    end
  end

  initial begin
    logic f, b, r;
    do_reset(3);
    // Fire alert, then reset while it is pending; fire held high must not re-alarm.
    hold(0, 0, 0, 0, 2);
    hold(1, 0, 0, 0, 10);
    do_reset(2);
    hold(1, 0, 0, 0, 20);
    hold(0, 0, 0, 0, 2);
    hold(1, 0, 0, 0, 6);
    hold(1, 0, 0, 1, 1);
    hold(0, 0, 0, 0, 3);
    // Rain alone: buzzer pattern, then mute after the timeout.
    do_reset(2);
    hold(0, 0, 1, 0, 60);
    hold(0, 0, 0, 1, 1);
    hold(0, 0, 0, 0, 3);
    // Burglar, then fire over it for 100+ ticks, then two acks.
    do_reset(2);
    hold(0, 1, 0, 0, 20);
    hold(1, 1, 0, 0, 420);
    hold(1, 1, 0, 1, 1);
    hold(1, 1, 0, 0, 20);
    hold(1, 1, 0, 1, 1);
    hold(1, 1, 0, 0, 5);
    // Burglar rise and ack in the same cycle while burglar is active.
    do_reset(2);
    hold(0, 1, 0, 0, 10);
    hold(0, 0, 0, 0, 2);
    hold(0, 1, 0, 1, 1);
    hold(0, 1, 0, 0, 10);
    // Rain muted, burglar arrives, ack returns to rain.
    do_reset(2);
    hold(0, 0, 1, 0, 50);
    hold(0, 1, 1, 0, 20);
    hold(0, 1, 1, 1, 1);
    hold(0, 1, 1, 0, 40);
    // 300 fire pulses: saturates the fire event counter when logging is built in.
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      hold(1, 0, 0, 0, 1);
      hold(0, 0, 0, 0, 1);
    end
    // Random traffic with occasional resets.
    do_reset(2);
    f = 0; b = 0; r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(31) == 0) f = ~f;
      if ($urandom_range(31) == 0) b = ~b;
      if ($urandom_range(23) == 0) r = ~r;
      if ($urandom_range(1499) == 0) do_reset($urandom_range(1, 3));
      else drive(f, b, r, logic'($urandom_range(23) == 0));
    end
    hold(0, 0, 0, 0, 2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
